// File: rtl/lr_bus_arbiter.sv
// Two-master arbiter for the 8-bit LR slave bus: registered grant, round-robin tie-break,
// occupy-based lock and bounded preemption. Define LR_ARB_PARK_EN to park the bus on the last owner.
module lr_bus_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 5
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       M0RD_i,
   input  logic       M0WR_i,
   input  logic [7:0] M0Addr_i,
   input  logic [7:0] M0WRData_i,
   input  logic       M0Occupy_i,
   output logic       M0Gnt_o,
   output logic [7:0] M0RDData_o,
   input  logic       M1RD_i,
   input  logic       M1WR_i,
   input  logic [7:0] M1Addr_i,
   input  logic [7:0] M1WRData_i,
   input  logic       M1Occupy_i,
   output logic       M1Gnt_o,
   output logic [7:0] M1RDData_o,
   output logic       SRD_o,
   output logic       SWR_o,
   output logic [7:0] SAddr_o,
   output logic [7:0] SWRData_o,
   input  logic [7:0] SRDData_i,
   output logic [1:0] Owner_o
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

`ifdef LR_ARB_PARK_EN
   localparam bit PARK = 1'b1;
`else
   localparam bit PARK = 1'b0;
`endif

   state_t            state, state_nxt;
   logic              last, last_nxt;
   logic [HOLD_W-1:0] hold, hold_nxt;
   logic              req0, req1;
   logic              hold_max;

   assign req0     = M0RD_i | M0WR_i | M0Occupy_i;
   assign req1     = M1RD_i | M1WR_i | M1Occupy_i;
   assign hold_max = (hold >= HOLD_W'(MAX_HOLD));

   // last = 1 after reset so that M0 wins the first tie
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         last  <= 1'b1;
         hold  <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         hold  <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      hold_nxt  = '0;
      case (state)
         IDLE: begin
            if (req0 && (!req1 || last))
               state_nxt = OWN0;
            else if (req1)
               state_nxt = OWN1;
         end
         OWN0: begin
            if (!req0) begin
               last_nxt = 1'b0;
               if (req1)
                  state_nxt = OWN1;
               else if (!PARK)
                  state_nxt = IDLE;
            end else if (req1 && !M0Occupy_i) begin
               if (hold_max) begin
                  state_nxt = OWN1;
                  last_nxt  = 1'b0;
               end else begin
                  hold_nxt = hold + 1'b1;
               end
            end
         end
         OWN1: begin
            if (!req1) begin
               last_nxt = 1'b1;
               if (req0)
                  state_nxt = OWN0;
               else if (!PARK)
                  state_nxt = IDLE;
            end else if (req0 && !M1Occupy_i) begin
               if (hold_max) begin
                  state_nxt = OWN0;
                  last_nxt  = 1'b1;
               end else begin
                  hold_nxt = hold + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Owner's strobes pass through unregistered; a simultaneous RD and WR becomes a write
   always_comb begin
      SRD_o     = 1'b0;
      SWR_o     = 1'b0;
      SAddr_o   = '0;
      SWRData_o = '0;
      case (state)
         OWN0: begin
            SRD_o     = M0RD_i & ~M0WR_i;
            SWR_o     = M0WR_i;
            SAddr_o   = M0Addr_i;
            SWRData_o = M0WRData_i;
         end
         OWN1: begin
            SRD_o     = M1RD_i & ~M1WR_i;
            SWR_o     = M1WR_i;
            SAddr_o   = M1Addr_i;
            SWRData_o = M1WRData_i;
         end
         default: ;
      endcase
   end

   assign M0Gnt_o    = (state == OWN0);
   assign M1Gnt_o    = (state == OWN1);
   assign Owner_o    = state;
   assign M0RDData_o = SRDData_i;
   assign M1RDData_o = SRDData_i;

endmodule

// File: tb/tb_lr_bus_arbiter.sv
// Directed-vector bench for lr_bus_arbiter (MAX_HOLD = 4); the parked-bus checks
// replace the release-to-IDLE checks when LR_ARB_PARK_EN is defined.
module tb_lr_bus_arbiter;

   logic       clk;
   logic       rstn;
   logic       M0RD_i, M0WR_i, M0Occupy_i, M0Gnt_o;
   logic [7:0] M0Addr_i, M0WRData_i, M0RDData_o;
   logic       M1RD_i, M1WR_i, M1Occupy_i, M1Gnt_o;
   logic [7:0] M1Addr_i, M1WRData_i, M1RDData_o;
   logic       SRD_o, SWR_o;
   logic [7:0] SAddr_o, SWRData_o, SRDData_i;
   logic [1:0] Owner_o;

   int vectorCount = 0;
   int failCount   = 0;

   lr_bus_arbiter #(.MAX_HOLD(4), .HOLD_W(3)) dut (
      .clk(clk), .rstn(rstn),
      .M0RD_i(M0RD_i), .M0WR_i(M0WR_i), .M0Addr_i(M0Addr_i), .M0WRData_i(M0WRData_i),
      .M0Occupy_i(M0Occupy_i), .M0Gnt_o(M0Gnt_o), .M0RDData_o(M0RDData_o),
      .M1RD_i(M1RD_i), .M1WR_i(M1WR_i), .M1Addr_i(M1Addr_i), .M1WRData_i(M1WRData_i),
      .M1Occupy_i(M1Occupy_i), .M1Gnt_o(M1Gnt_o), .M1RDData_o(M1RDData_o),
      .SRD_o(SRD_o), .SWR_o(SWR_o), .SAddr_o(SAddr_o), .SWRData_o(SWRData_o),
      .SRDData_i(SRDData_i), .Owner_o(Owner_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(
      input logic m0rd, input logic m0wr, input logic [7:0] m0addr, input logic [7:0] m0data, input logic m0occ,
      input logic m1rd, input logic m1wr, input logic [7:0] m1addr, input logic [7:0] m1data, input logic m1occ);
      M0RD_i = m0rd; M0WR_i = m0wr; M0Addr_i = m0addr; M0WRData_i = m0data; M0Occupy_i = m0occ;
      M1RD_i = m1rd; M1WR_i = m1wr; M1Addr_i = m1addr; M1WRData_i = m1data; M1Occupy_i = m1occ;
      #1;
   endtask

   task automatic nextCycle;
      @(posedge clk);
      #2;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_gnt0"}, M0Gnt_o, 0);
      checkOutput({tag, "_gnt1"}, M1Gnt_o, 0);
      checkOutput({tag, "_owner"}, Owner_o, 0);
      checkOutput({tag, "_srd"}, SRD_o, 0);
      checkOutput({tag, "_swr"}, SWR_o, 0);
      checkOutput({tag, "_saddr"}, SAddr_o, 0);
      checkOutput({tag, "_swrdata"}, SWRData_o, 0);
   endtask

   task automatic runReleaseTests;
      // single read from IDLE, data returns the cycle after the strobe
      applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
      checkOutput("a_pre_gnt0", M0Gnt_o, 0);
      checkOutput("a_pre_srd", SRD_o, 0);
      nextCycle;
      checkOutput("a_gnt0", M0Gnt_o, 1);
      checkOutput("a_owner", Owner_o, 2'b01);
      checkOutput("a_srd", SRD_o, 1);
      checkOutput("a_saddr", SAddr_o, 8'h10);
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
      nextCycle;
      SRDData_i = 8'hA5;
      #1;
      checkOutput("a_rddata0", M0RDData_o, 8'hA5);
      checkOutput("a_idle_owner", Owner_o, 2'b00);
      checkOutput("a_idle_gnt0", M0Gnt_o, 0);

      // tie with last = M0 goes to M1, then direct handoff back to M0
      applyStimulus(1, 0, 8'h20, 8'h00, 0, 1, 0, 8'h30, 8'h00, 0);
      nextCycle;
      checkOutput("b_tie_owner", Owner_o, 2'b10);
      checkOutput("b_tie_gnt1", M1Gnt_o, 1);
      checkOutput("b_tie_saddr", SAddr_o, 8'h30);
      applyStimulus(1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
      nextCycle;
      checkOutput("b_handoff_owner", Owner_o, 2'b01);
      checkOutput("b_handoff_saddr", SAddr_o, 8'h20);
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
      nextCycle;
      checkOutput("b_idle_owner", Owner_o, 2'b00);

      // preemption after MAX_HOLD waiting cycles, in both directions
      applyStimulus(0, 1, 8'h40, 8'h11, 0, 0, 0, 8'h00, 8'h00, 0);
      nextCycle;
      checkOutput("c_own0", Owner_o, 2'b01);
      applyStimulus(0, 1, 8'h40, 8'h11, 0, 1, 0, 8'h50, 8'h00, 0);
      for (int i = 1; i <= 4; i++) begin
         nextCycle;
         checkOutput($sformatf("c_wait1_%0d", i), M1Gnt_o, 0);
      end
      nextCycle;
      checkOutput("c_preempt_gnt1", M1Gnt_o, 1);
      checkOutput("c_preempt_owner", Owner_o, 2'b10);
      checkOutput("c_preempt_saddr", SAddr_o, 8'h50);
      checkOutput("c_preempt_swr", SWR_o, 0);
      for (int i = 1; i <= 4; i++) begin
         nextCycle;
         checkOutput($sformatf("c_wait0_%0d", i), M0Gnt_o, 0);
      end
      nextCycle;
      checkOutput("c_back_gnt0", M0Gnt_o, 1);
      checkOutput("c_back_swdata", SWRData_o, 8'h11);
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
      nextCycle;
      checkOutput("c_idle_owner", Owner_o, 2'b00);

      // occupy lock holds the bus against a waiting master
      applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0);
      nextCycle;
      checkOutput("d_own0", Owner_o, 2'b01);
      applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h60, 8'h00, 0);
      for (int i = 0; i < 100; i++) begin
         nextCycle;
         checkOutput($sformatf("d_lock_%0d", i), M0Gnt_o, 1);
      end
      checkOutput("d_lock_srd", SRD_o, 0);
      checkOutput("d_lock_saddr", SAddr_o, 8'h00);
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h60, 8'h00, 0);
      nextCycle;
      checkOutput("d_unlock_gnt1", M1Gnt_o, 1);
      checkOutput("d_unlock_owner", Owner_o, 2'b10);
      checkOutput("d_unlock_srd", SRD_o, 1);
      checkOutput("d_unlock_saddr", SAddr_o, 8'h60);

      // RD and WR together is a write; non-owner strobes stay off the bus
      applyStimulus(1, 1, 8'h55, 8'h3C, 0, 0, 0, 8'h00, 8'h00, 0);
      nextCycle;
      checkOutput("e_gnt0", M0Gnt_o, 1);
      checkOutput("e_swr", SWR_o, 1);
      checkOutput("e_srd", SRD_o, 0);
      checkOutput("e_swrdata", SWRData_o, 8'h3C);
      checkOutput("e_saddr", SAddr_o, 8'h55);
      applyStimulus(1, 1, 8'h55, 8'h3C, 0, 0, 1, 8'h99, 8'hEE, 0);
      checkOutput("e_m1_blocked_saddr", SAddr_o, 8'h55);
      checkOutput("e_m1_blocked_data", SWRData_o, 8'h3C);
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h99, 8'hEE, 0);
      checkOutput("e_released_swr", SWR_o, 0);
      nextCycle;
      checkOutput("e_gnt1", M1Gnt_o, 1);
      checkOutput("e_m1_swr", SWR_o, 1);
      checkOutput("e_m1_swrdata", SWRData_o, 8'hEE);
      checkOutput("e_m1_saddr", SAddr_o, 8'h99);
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
      nextCycle;
      checkOutput("e_idle_owner", Owner_o, 2'b00);
   endtask

   task automatic runResetMidTransfer;
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h77, 8'h00, 0);
      nextCycle;
      checkOutput("f_own1", Owner_o, 2'b10);
      checkOutput("f_srd", SRD_o, 1);
      #1;
      rstn = 1'b0;
      #1;
      checkAllZero("f_async_rst");
      applyStimulus(1, 0, 8'h21, 8'h00, 0, 1, 0, 8'h77, 8'h00, 0);
      rstn = 1'b1;
      nextCycle;
      checkOutput("f_tie_owner", Owner_o, 2'b01);
      checkOutput("f_tie_gnt0", M0Gnt_o, 1);
      checkOutput("f_tie_saddr", SAddr_o, 8'h21);
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h77, 8'h00, 0);
      nextCycle;
      checkOutput("f_handoff_owner", Owner_o, 2'b10);
      checkOutput("f_handoff_gnt1", M1Gnt_o, 1);
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
      nextCycle;
`ifdef LR_ARB_PARK_EN
      checkOutput("p_parked_gnt1", M1Gnt_o, 1);
      checkOutput("p_parked_owner", Owner_o, 2'b10);
      checkOutput("p_parked_srd", SRD_o, 0);
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h66, 8'h00, 0);
      checkOutput("p_rereq_srd", SRD_o, 1);
      checkOutput("p_rereq_saddr", SAddr_o, 8'h66);
      applyStimulus(1, 0, 8'h12, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
      checkOutput("p_other_wait", M0Gnt_o, 0);
      nextCycle;
      checkOutput("p_other_gnt0", M0Gnt_o, 1);
      checkOutput("p_other_saddr", SAddr_o, 8'h12);
`else
      checkOutput("f_idle_owner", Owner_o, 2'b00);
      checkOutput("f_idle_gnt1", M1Gnt_o, 0);
`endif
   endtask

   initial begin
      rstn      = 1'b0;
      SRDData_i = 8'h00;
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
      #2;
      checkAllZero("reset");
      @(posedge clk);
      @(posedge clk);
      #2;
      rstn = 1'b1;
`ifndef LR_ARB_PARK_EN
      runReleaseTests;
`endif
      runResetMidTransfer;
      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
      $finish;
   end

endmodule

// File: doc/lr_bus_arbiter.md
Name: lr_bus_arbiter

Overview:
- Shares the single 8-bit LR slave bus (memory/peripheral space) between two LR masters.
- M0 is the Processor; M1 is a second master (DMA or debug loader).
- Registered grant with round-robin tie-break, bus lock via the master's occupy signal, and bounded preemption of non-locked owners.
- Sits between the masters' LRMaster* ports and the LR slave decoder.

Parameters:
- MAX_HOLD, 16, cycles a non-locked owner may keep the bus while the other master waits; must be ≥1.
- HOLD_W, 5, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- M0RD_i  in  1  M0 read strobe
- M0WR_i  in  1  M0 write strobe
- M0Addr_i  in  8  M0 address
- M0WRData_i  in  8  M0 write data
- M0Occupy_i  in  1  M0 bus lock (Processor LROccupy_o)
- M0Gnt_o  out  1  M0 owns the bus this cycle
- M0RDData_o  out  8  read data to M0
- M1RD_i, M1WR_i, M1Addr_i, M1WRData_i, M1Occupy_i, M1Gnt_o, M1RDData_o: same as the M0 set, for M1
- SRD_o  out  1  slave read strobe
- SWR_o  out  1  slave write strobe
- SAddr_o  out  8  slave address
- SWRData_o  out  8  slave write data
- SRDData_i  in  8  slave read data, valid the cycle after SRD_o
- Owner_o  out  2  00 none, 01 M0, 10 M1

Behaviour:
- Request: reqN = MNRD_i | MNWR_i | MNOccupy_i.
- State register: IDLE, OWN0, OWN1. Owner_o and MNGnt_o decode the state directly (registered, glitch-free).
- last register: last-served master.
- Reset (async, any time, including mid-transfer):
  - state IDLE, last=M1 (M0 wins the first tie), hold counter 0.
  - All outputs 0: SRD_o=SWR_o=0, SAddr_o=SWRData_o=0, gnts=0, Owner_o=00.
- IDLE:
  - Only req0 → OWN0. Only req1 → OWN1.
  - Both → the master that is not last.
  - Neither → stay in IDLE.
- Grant latency: a request first seen in IDLE at edge t gives gnt high from cycle t+1.
  - A master holds RD/WR/Addr/WRData stable until it samples its gnt high.
  - Non-owner strobes never reach the slave.
- OWNx:
  - The owner's RD, WR, Addr and WRData drive S* combinationally. Not registered: zero added bus latency.
  - Owner RD=WR=1 in the same cycle → SWR_o=1, SRD_o=0 (write wins).
- Read data: SRDData_i is broadcast to both MNRDData_o.
  - Valid for the master that owned the bus in the previous cycle; a released owner still gets its final read beat.
- Release from OWNx when reqx=0:
  - Other master requesting → go directly to its OWN state; gnt moves in one edge, no dead cycle.
  - Otherwise → IDLE.
  - Set last=x in both cases.
- Hold counter:
  - Increments each OWNx cycle in which the other master requests and Occupy_x=0.
  - Clears on any state change, or when the other master stops requesting, or when Occupy_x=1.
  - Reaching MAX_HOLD → next edge forces the switch to the other master and sets last=x.
  - The preempted master sees gnt drop and must re-issue its strobe after regaining gnt.
- Lock: Occupy_x=1 blocks preemption indefinitely. The owner still releases normally when reqx drops.
- Occupy from the non-owner only counts as a request; it cannot take the bus.
- S* outputs in IDLE: all 0.

Optional Feature:
LR_ARB_PARK_EN:
- Defined: when no master requests, the bus parks on last (owner and gnt stay asserted, S* strobes follow the parked master = 0).
  - A parked master re-requesting gets the bus with zero grant latency.
  - The other master's request while parked is granted at the next edge.
  - IDLE is visited only after reset, until the first grant.
- Undefined: the behaviour above (return to IDLE, gnts low).

Test Plan:
- M0RD_i=1, Addr=0x10 from IDLE → M0Gnt_o=1 next cycle; SRD_o=1, SAddr_o=0x10; SRDData_i=0xA5 the following cycle → M0RDData_o=0xA5.
- M0 and M1 both request first out of reset → M0 granted; M0 drops → M1 granted on the very next edge with no IDLE cycle; Owner_o goes 01→10.
- M0 owns without Occupy while M1 requests continuously, MAX_HOLD=4 → M1Gnt_o=1 exactly 5 cycles after M1 began waiting; hold counter clears.
- M0Occupy_i=1 with M1 requesting for 100 cycles → M0 keeps the bus throughout; Occupy drops and M0RD/WR drop → M1 granted next edge.
- Owner drives RD=WR=1, WRData=0x3C → SWR_o=1, SRD_o=0, SWRData_o=0x3C; M1 strobes during M0 ownership → no S* activity.
- rstn pulsed low mid-transfer while OWN1 → all outputs 0 asynchronously; after release a simultaneous request grants M0. Repeat with LR_ARB_PARK_EN: after M1 goes idle, M1Gnt_o stays 1 and an M1 re-request issues on SRD_o the same cycle.
